sd_cmd_response_receiver: RTL and testbench

- Receives an SD CMD-line response of a selectable type (none, R1/R6/R7 48-bit with CRC, R3 48-bit without CRC, R2 136-bit).
- Frames the response itself: start-bit detection and an Ncr timeout counter. Checks CRC7, transmission and end bits, and the index field.
- Sits between the command transmitter and the host register interface. Started by the command FSM after the command end bit is sent.
- Parametrised successor of the fixed-length response shift register.

---
 rtl/sd_cmd_pkg.sv | 22 ++
 rtl/sd_crc7_serial.sv | 39 +++
 rtl/sd_cmd_response_receiver.sv | 196 +++++++++++++++++++
 tb/tb_sd_cmd_response_receiver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// rtl/sd_cmd_pkg.sv - shared types and constants for the SD CMD-line response path
package sd_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_RECEIVE    = 2'd2,
        ST_CHECK      = 2'd3
    } rx_state_e;

    localparam logic [1:0] RESP_NONE        = 2'd0;
    localparam logic [1:0] RESP_SHORT       = 2'd1;
    localparam logic [1:0] RESP_SHORT_NOCRC = 2'd2;
    localparam logic [1:0] RESP_LONG        = 2'd3;

    // x^7 + x^3 + 1 with the x^7 term implied by the shift
    localparam logic [6:0] CRC7_TAPS = 7'h09;

    // R2/R3 carry all ones where R1-style responses carry the command index
    localparam logic [5:0] CHECK_FIELD_ONES = 6'h3F;

endpackage

// File: rtl/sd_crc7_serial.sv
// rtl/sd_crc7_serial.sv - bit-serial CRC7 generator shared by CMD transmit and receive
module sd_crc7_serial
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_in,
    output logic [6:0] crc_out
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       feedback;

    // Next CRC value: clear takes priority over a data step
    always_comb begin
        crc_d    = crc_q;
        feedback = data_in ^ crc_q[6];
        if (clear) begin
            crc_d = '0;
        end else if (enable) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (feedback ? CRC7_TAPS : 7'd0);
        end
    end

    // CRC register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/sd_cmd_response_receiver.sv
// rtl/sd_cmd_response_receiver.sv - frames and checks an SD CMD-line response
module sd_cmd_response_receiver
    import sd_cmd_pkg::*;
#(
    parameter int RESP_TIMEOUT = 64,
    parameter int TO_W         = 7,
    parameter int SHORT_BITS   = 48,
    parameter int LONG_BITS    = 136
) (
    input  logic         in_sd_clk,
    input  logic         hrst_n,
    input  logic         in_soft_reset,
    input  logic         in_start,
    input  logic [1:0]   in_resp_type,
    input  logic [5:0]   in_cmd_index,
    input  logic         in_serial_cmd,
    output logic         out_busy,
    output logic         out_done,
    output logic [127:0] out_response,
    output logic         out_crc_error,
    output logic         out_frame_error,
    output logic         out_index_error,
    output logic         out_timeout_error
);

    localparam int CNT_W     = $clog2(LONG_BITS);
    // The start bit never needs to be kept, so the register is two short of a long frame
    localparam int SR_W      = LONG_BITS - 2;
    localparam int ARG_W     = SHORT_BITS - 16;
    localparam int PAYLOAD_W = LONG_BITS - 16;

    localparam logic [CNT_W-1:0] SHORT_LAST     = CNT_W'(SHORT_BITS - 1);
    localparam logic [CNT_W-1:0] LONG_LAST      = CNT_W'(LONG_BITS - 1);
    localparam logic [CNT_W-1:0] SHORT_CRC_LAST = CNT_W'(SHORT_BITS - 9);
    localparam logic [CNT_W-1:0] LONG_CRC_FIRST = CNT_W'(8);
    localparam logic [CNT_W-1:0] LONG_CRC_LAST  = CNT_W'(LONG_BITS - 9);
    localparam logic [TO_W-1:0]  TO_LAST        = TO_W'(RESP_TIMEOUT - 1);

    logic            rst_n;
    rx_state_e       state_q, state_d;
    logic [1:0]      type_q, type_d;
    logic [5:0]      idx_q, idx_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SR_W-1:0] frame_q, frame_d;
    logic [127:0]    resp_q, resp_d;
    logic            crc_err_q, crc_err_d;
    logic            frame_err_q, frame_err_d;
    logic            index_err_q, index_err_d;
    logic            timeout_err_q, timeout_err_d;

    logic [SR_W:0]   frame_w;
    logic            crc_clear, crc_en;
    logic [6:0]      crc_calc;
    logic            last_bit, crc_window;
    logic            trans_bit, end_bit;
    logic [5:0]      check_field, exp_field;
    logic [6:0]      rx_crc;
    logic [127:0]    rx_resp;

    assign rst_n   = hrst_n & in_soft_reset;
    // Frame as it stands once the bit on the line this cycle is shifted in
    assign frame_w = {frame_q, in_serial_cmd};

    sd_crc7_serial u_crc7 (
        .clk     (in_sd_clk),
        .resetn  (rst_n),
        .clear   (crc_clear),
        .enable  (crc_en),
        .data_in (in_serial_cmd),
        .crc_out (crc_calc)
    );

    // Field decode of the completed frame, valid on the end-bit cycle
    always_comb begin
        rx_resp = '0;
        end_bit = frame_w[0];
        rx_crc  = frame_w[7:1];
        if (type_q == RESP_LONG) begin
            last_bit                 = (bit_cnt_q == LONG_LAST);
            crc_window               = (bit_cnt_q >= LONG_CRC_FIRST) && (bit_cnt_q <= LONG_CRC_LAST);
            trans_bit                = frame_w[LONG_BITS-2];
            check_field              = frame_w[LONG_BITS-3 -: 6];
            rx_resp[PAYLOAD_W-1:0]   = frame_w[LONG_BITS-9:8];
        end else begin
            last_bit                 = (bit_cnt_q == SHORT_LAST);
            crc_window               = (bit_cnt_q <= SHORT_CRC_LAST);
            trans_bit                = frame_w[SHORT_BITS-2];
            check_field              = frame_w[SHORT_BITS-3 -: 6];
            rx_resp[ARG_W-1:0]       = frame_w[SHORT_BITS-9 -: ARG_W];
        end
        exp_field = (type_q == RESP_SHORT) ? idx_q : CHECK_FIELD_ONES;
    end

    // Receive FSM: next state, counters, capture and result flags
    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        idx_d         = idx_q;
        to_cnt_d      = to_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        frame_d       = frame_q;
        resp_d        = resp_q;
        crc_err_d     = crc_err_q;
        frame_err_d   = frame_err_q;
        index_err_d   = index_err_q;
        timeout_err_d = timeout_err_q;
        crc_clear     = 1'b0;
        crc_en        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    type_d        = in_resp_type;
                    idx_d         = in_cmd_index;
                    to_cnt_d      = '0;
                    resp_d        = '0;
                    crc_err_d     = 1'b0;
                    frame_err_d   = 1'b0;
                    index_err_d   = 1'b0;
                    timeout_err_d = 1'b0;
                    state_d       = (in_resp_type == RESP_NONE) ? ST_CHECK : ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                // Line low is the start bit, even on the cycle the timeout would fire
                if (!in_serial_cmd) begin
                    bit_cnt_d = CNT_W'(1);
                    frame_d   = '0;
                    crc_clear = 1'b1;
                    state_d   = ST_RECEIVE;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_CHECK;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_RECEIVE: begin
                frame_d   = frame_w[SR_W-1:0];
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                crc_en    = crc_window;
                if (last_bit) begin
                    resp_d      = rx_resp;
                    frame_err_d = trans_bit | ~end_bit;
                    index_err_d = (check_field != exp_field);
                    crc_err_d   = (type_q != RESP_SHORT_NOCRC) && (rx_crc != crc_calc);
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge in_sd_clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            type_q        <= RESP_NONE;
            idx_q         <= '0;
            to_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            frame_q       <= '0;
            resp_q        <= '0;
            crc_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            index_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            idx_q         <= idx_d;
            to_cnt_q      <= to_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_q       <= frame_d;
            resp_q        <= resp_d;
            crc_err_q     <= crc_err_d;
            frame_err_q   <= frame_err_d;
            index_err_q   <= index_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign out_busy          = (state_q != ST_IDLE);
    assign out_done          = (state_q == ST_CHECK);
    assign out_response      = resp_q;
    assign out_crc_error     = crc_err_q;
    assign out_frame_error   = frame_err_q;
    assign out_index_error   = index_err_q;
    assign out_timeout_error = timeout_err_q;

endmodule

// File: tb/tb_sd_cmd_response_receiver.sv
// tb/tb_sd_cmd_response_receiver.sv - directed scoreboard bench for sd_cmd_response_receiver
module tb_sd_cmd_response_receiver;

    localparam int RESP_TIMEOUT = 64;

    logic         in_sd_clk = 1'b0;
    logic         hrst_n;
    logic         in_soft_reset;
    logic         in_start;
    logic [1:0]   in_resp_type;
    logic [5:0]   in_cmd_index;
    logic         in_serial_cmd;
    logic         out_busy;
    logic         out_done;
    logic [127:0] out_response;
    logic         out_crc_error;
    logic         out_frame_error;
    logic         out_index_error;
    logic         out_timeout_error;

    typedef struct {
        string        tag;
        logic [127:0] resp;
        logic         crc;
        logic         frm;
        logic         idx;
        logic         to;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    sd_cmd_response_receiver #(
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .TO_W         (7),
        .SHORT_BITS   (48),
        .LONG_BITS    (136)
    ) dut (
        .in_sd_clk         (in_sd_clk),
        .hrst_n            (hrst_n),
        .in_soft_reset     (in_soft_reset),
        .in_start          (in_start),
        .in_resp_type      (in_resp_type),
        .in_cmd_index      (in_cmd_index),
        .in_serial_cmd     (in_serial_cmd),
        .out_busy          (out_busy),
        .out_done          (out_done),
        .out_response      (out_response),
        .out_crc_error     (out_crc_error),
        .out_frame_error   (out_frame_error),
        .out_index_error   (out_index_error),
        .out_timeout_error (out_timeout_error)
    );

    always #5 in_sd_clk = ~in_sd_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge in_sd_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference CRC7 by polynomial long division of the message times x^7
    function automatic logic [6:0] crc7_ref(input logic [127:0] msg, input int nbits);
        logic [7:0] rem = 8'h00;
        for (int i = nbits - 1; i >= -7; i--) begin
            rem = {rem[6:0], (i >= 0) ? msg[i] : 1'b0};
            if (rem[7]) rem = rem ^ 8'h89;
        end
        return rem[6:0];
    endfunction

    function automatic logic [135:0] short_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [127:0] m = '0;
        m[39:0] = {2'b00, idx, arg};
        return {88'h0, 2'b00, idx, arg, crc7_ref(m, 40), 1'b1};
    endfunction

    function automatic logic [135:0] long_frame(input logic [119:0] pl);
        logic [127:0] m = '0;
        m[119:0] = pl;
        return {2'b00, 6'h3F, pl, crc7_ref(m, 120), 1'b1};
    endfunction

    task automatic start(input logic [1:0] t, input logic [5:0] idx);
        in_start     = 1'b1;
        in_resp_type = t;
        in_cmd_index = idx;
        tick();
        in_start     = 1'b0;
    endtask

    task automatic send_frame(input logic [135:0] fr, input int n, input string tag);
        bit early = 1'b0;
        for (int k = 0; k < n; k++) begin
            in_serial_cmd = fr[n-1-k];
            tick();
            if (k < n - 1 && out_done) early = 1'b1;
        end
        in_serial_cmd = 1'b1;
        check({tag, "_early_done"}, 128'(early), 128'(0));
        check({tag, "_done_latency"}, 128'(out_done), 128'(1));
    endtask

    task automatic push(input string tag, input logic [127:0] resp,
                        input logic crc, input logic frm, input logic idx, input logic to);
        sb.push_back('{tag: tag, resp: resp, crc: crc, frm: frm, idx: idx, to: to});
    endtask

    task automatic pop_check();
        exp_t e;
        check("sb_nonempty", 128'(sb.size() > 0), 128'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_resp"}, out_response, e.resp);
            check({e.tag, "_crc"}, 128'(out_crc_error), 128'(e.crc));
            check({e.tag, "_frame"}, 128'(out_frame_error), 128'(e.frm));
            check({e.tag, "_index"}, 128'(out_index_error), 128'(e.idx));
            check({e.tag, "_timeout"}, 128'(out_timeout_error), 128'(e.to));
            tick();
            check({e.tag, "_done_pulse"}, 128'({out_done, out_busy}), 128'(0));
        end
    endtask

    initial begin
        logic [135:0] fr;
        int           cyc;
        bit           seen;

        hrst_n        = 1'b0;
        in_soft_reset = 1'b1;
        in_start      = 1'b0;
        in_resp_type  = 2'd0;
        in_cmd_index  = 6'd0;
        in_serial_cmd = 1'b1;
        tick();
        tick();
        check("rst_busy", 128'(out_busy), 128'(0));
        check("rst_done", 128'(out_done), 128'(0));
        check("rst_resp", out_response, 128'(0));
        check("rst_errors", 128'({out_crc_error, out_frame_error, out_index_error, out_timeout_error}), 128'(0));
        hrst_n = 1'b1;
        tick();

        // R7 to CMD8 after three idle cycles; a type-0 start while busy must be ignored
        push("r7", 128'h1AA, 1'b0, 1'b0, 1'b0, 1'b0);
        start(2'd1, 6'd8);
        tick();
        in_start = 1'b1;
        in_resp_type = 2'd0;
        tick();
        in_start = 1'b0;
        tick();
        check("r7_busy_wait", 128'(out_busy), 128'(1));
        fr = 136'h08000001AA13;
        send_frame(fr, 48, "r7");
        pop_check();

        // Argument bit flipped in flight: only the CRC check trips
        push("r7_crc", 128'h000801AA, 1'b1, 1'b0, 1'b0, 1'b0);
        start(2'd1, 6'd8);
        fr = 136'h08000001AA13;
        fr[47-20] = ~fr[47-20];
        send_frame(fr, 48, "r7_crc");
        pop_check();

        // No response expected: done the very next cycle, errors cleared
        push("none", 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        start(2'd0, 6'd0);
        check("none_done_latency", 128'(out_done), 128'(1));
        pop_check();

        // R3: good frame, then garbage in the CRC bits is still not an error
        push("r3", 128'h80FF8000, 1'b0, 1'b0, 1'b0, 1'b0);
        start(2'd2, 6'd41);
        send_frame(136'h3F80FF8000FF, 48, "r3");
        pop_check();
        push("r3_junk", 128'h80FF8000, 1'b0, 1'b0, 1'b0, 1'b0);
        start(2'd2, 6'd41);
        send_frame(136'h3F80FF8000A5, 48, "r3_junk");
        pop_check();

        // R2: good long frame, then same frame with the end bit low
        push("r2", 128'h0123456789ABCDEF0123456789ABEF, 1'b0, 1'b0, 1'b0, 1'b0);
        start(2'd3, 6'd2);
        send_frame(long_frame(120'h0123456789ABCDEF0123456789ABEF), 136, "r2");
        pop_check();
        push("r2_end", 128'h0123456789ABCDEF0123456789ABEF, 1'b0, 1'b1, 1'b0, 1'b0);
        start(2'd3, 6'd2);
        fr = long_frame(120'h0123456789ABCDEF0123456789ABEF);
        fr[0] = 1'b0;
        send_frame(fr, 136, "r2_end");
        pop_check();

        // Line stays high: timeout reported RESP_TIMEOUT+1 cycles after the start pulse
        push("tmo", 128'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        start(2'd1, 6'd8);
        cyc = 1;
        while (!out_done && cyc < 200) begin
            tick();
            cyc++;
        end
        check("tmo_latency", 128'(cyc), 128'(RESP_TIMEOUT + 1));
        pop_check();

        // Start bit on the cycle the counter reaches its limit wins over the timeout
        push("late_start", 128'h1AA, 1'b0, 1'b0, 1'b0, 1'b0);
        start(2'd1, 6'd8);
        repeat (RESP_TIMEOUT - 1) tick();
        send_frame(136'h08000001AA13, 48, "late_start");
        pop_check();

        // Soft reset at bit 20 aborts the frame with no done
        start(2'd1, 6'd8);
        fr = 136'h08000001AA13;
        for (int k = 0; k < 20; k++) begin
            in_serial_cmd = fr[47-k];
            tick();
        end
        in_serial_cmd = fr[47-20];
        in_soft_reset = 1'b0;
        tick();
        check("srst_busy", 128'(out_busy), 128'(0));
        check("srst_outputs", {out_response[127:5], out_done, out_crc_error, out_frame_error,
                               out_index_error, out_timeout_error} | 128'(out_response[4:0]), 128'(0));
        in_soft_reset = 1'b1;
        seen = 1'b0;
        for (int k = 21; k < 60; k++) begin
            in_serial_cmd = (k < 48) ? fr[47-k] : 1'b1;
            tick();
            if (out_done || out_busy) seen = 1'b1;
        end
        in_serial_cmd = 1'b1;
        check("srst_no_done", 128'(seen), 128'(0));

        // Index field 16 against an issued CMD17
        push("idx", 128'h00000900, 1'b0, 1'b0, 1'b1, 1'b0);
        start(2'd1, 6'd17);
        send_frame(short_frame(6'd16, 32'h00000900), 48, "idx");
        pop_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
